// File: rtl/fdtd_ez_select_pipe_pkg.sv
// Shared types and constants for the FDTD Ez source-select pipeline.
// The buffer-state encoding doubles as the occupancy count (0, 1 or 2 samples).
package fdtd_pkg;

  localparam int FDTD_DEF_DATA_WIDTH = 32;

  localparam int FDTD_SEL_STRICT = 0;
  localparam int FDTD_SEL_PRIO   = 1;

  typedef logic signed [FDTD_DEF_DATA_WIDTH-1:0] fdtd_data_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fdtd_ez_select_pipe_if.sv
// Source-side and sink-side bus of the Ez select pipeline.
// Handshake: a sample moves on a rising clock edge where valid (|src_en_i or
// out_valid_o) and ready (in_ready_o or out_ready_i) are both high; while valid
// is high and ready is low the producer holds its payload unchanged.
interface fdtd_ez_select_pipe_if
  import fdtd_pkg::*;
#(
  parameter int W  = FDTD_DEF_DATA_WIDTH,
  parameter int N  = 4,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]        src_en_i;
  logic [N*W-1:0]      src_data_i;
  logic                in_ready_o;
  logic                out_valid_o;
  logic                out_ready_i;
  logic signed [W-1:0] Ez_n_o;
  logic [IW-1:0]       sel_idx_o;

  modport master (
    output src_en_i, src_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, Ez_n_o, sel_idx_o
  );

  modport slave (
    input  src_en_i, src_data_i, out_ready_i,
    output in_ready_o, out_valid_o, Ez_n_o, sel_idx_o
  );
endinterface

// File: rtl/fdtd_ez_select_pipe_skid_buf.sv
// Generic 2-entry valid/ready buffer (main + skid) with a registered in_ready_o.
// Payload width is a parameter so the same block serves the Hx/Hy paths.
module fdtd_skid_buf
  import fdtd_pkg::*;
#(
  parameter int PW = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  input  logic [PW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [PW-1:0] out_data_o,
  input  logic          out_ready_i,
  output logic [1:0]    state_o
);

  localparam logic [1:0] ST_EMPTY = BUF_EMPTY;
  localparam logic [1:0] ST_ONE   = BUF_ONE;
  localparam logic [1:0] ST_FULL  = BUF_FULL;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic          xfer;

  assign xfer = in_valid_i & in_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer) begin
          main_d  = in_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (xfer && out_ready_i) begin
          main_d = in_data_i;
        end else if (xfer) begin
          skid_d  = in_data_i;
          state_d = ST_FULL;
        end else if (out_ready_i) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready_i) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Ready looks at the next state so it is a flop, not a path from out_ready_i.
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign state_o     = state_q;

endmodule

// File: rtl/fdtd_ez_select_pipe.sv
// Registered Ez source selector: per-source enables pick one of NUM_SRC samples,
// multi-hot patterns are flagged and counted, the result leaves through a skid buffer.
module fdtd_ez_select_pipe
  import fdtd_pkg::*;
#(
  parameter int FDTD_DATA_WIDTH = 32,
  parameter int NUM_SRC         = 4,
  parameter int PRIO_MODE       = FDTD_SEL_STRICT,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 clear_i,
  fdtd_ez_select_pipe_if.slave bus,
  output logic                 conflict_o,
  output logic [CNT_WIDTH-1:0] conflict_cnt_o,
  output logic [1:0]           buf_state_o
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int PW = IW + FDTD_DATA_WIDTH;
  localparam logic [NUM_SRC-1:0] EN_ONE = NUM_SRC'(1);

  logic                       any_en;
  logic                       multi_hot;
  logic                       accept;
  logic                       buf_in_ready;
  logic [IW-1:0]              sel_idx;
  logic [FDTD_DATA_WIDTH-1:0] sel_data;
  logic [PW-1:0]              buf_out;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       flag_q, flag_d;

  assign any_en    = |bus.src_en_i;
  assign multi_hot = (bus.src_en_i & (bus.src_en_i - EN_ONE)) != '0;
  assign accept    = any_en & buf_in_ready;

  // Downward scan so the lowest set index is the last one written.
  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (bus.src_en_i[k]) begin
        sel_idx  = IW'(k);
        sel_data = bus.src_data_i[k*FDTD_DATA_WIDTH +: FDTD_DATA_WIDTH];
      end
    end
    if (multi_hot && (PRIO_MODE == FDTD_SEL_STRICT)) begin
      sel_idx  = '0;
      sel_data = '0;
    end
  end

  // Clear has priority over a conflict arriving in the same cycle.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clear_i) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (accept && multi_hot) begin
      flag_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  fdtd_skid_buf #(
    .PW(PW)
  ) u_skid (
    .clk        (CLK),
    .rst_n      (RST_N),
    .in_valid_i (any_en),
    .in_data_i  ({sel_idx, sel_data}),
    .in_ready_o (buf_in_ready),
    .out_valid_o(bus.out_valid_o),
    .out_data_o (buf_out),
    .out_ready_i(bus.out_ready_i),
    .state_o    (buf_state_o)
  );

  assign bus.in_ready_o = buf_in_ready;
  assign bus.sel_idx_o  = buf_out[PW-1 -: IW];
  assign bus.Ez_n_o     = buf_out[FDTD_DATA_WIDTH-1:0];
  assign conflict_o     = flag_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_fdtd_ez_select_pipe.sv
// Bench for fdtd_ez_select_pipe: a strict-mode and a priority-mode instance share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_fdtd_ez_select_pipe;
  import fdtd_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int PW = 2 + W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0] en;
  logic [W-1:0] data [N];
  logic         out_ready;
  logic         clear;
  logic         chk_on = 1'b0;

  logic        conf0, conf1;
  logic [15:0] cnt0_o;
  logic [3:0]  cnt1_o;
  logic [1:0]  st0, st1;

  fdtd_ez_select_pipe_if #(.W(W), .N(N)) if0 ();
  fdtd_ez_select_pipe_if #(.W(W), .N(N)) if1 ();

  assign if0.src_en_i    = en;
  assign if1.src_en_i    = en;
  assign if0.src_data_i  = {data[3], data[2], data[1], data[0]};
  assign if1.src_data_i  = {data[3], data[2], data[1], data[0]};
  assign if0.out_ready_i = out_ready;
  assign if1.out_ready_i = out_ready;

  fdtd_ez_select_pipe #(
    .FDTD_DATA_WIDTH(W), .NUM_SRC(N), .PRIO_MODE(FDTD_SEL_STRICT), .CNT_WIDTH(16)
  ) dut0 (
    .CLK(clk), .RST_N(rst_n), .clear_i(clear), .bus(if0.slave),
    .conflict_o(conf0), .conflict_cnt_o(cnt0_o), .buf_state_o(st0)
  );

  fdtd_ez_select_pipe #(
    .FDTD_DATA_WIDTH(W), .NUM_SRC(N), .PRIO_MODE(FDTD_SEL_PRIO), .CNT_WIDTH(4)
  ) dut1 (
    .CLK(clk), .RST_N(rst_n), .clear_i(clear), .bus(if1.slave),
    .conflict_o(conf1), .conflict_cnt_o(cnt1_o), .buf_state_o(st1)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];
  int  m_cnt0 = 0;
  int  m_cnt1 = 0;
  bit  m_flg0 = 1'b0;
  bit  m_flg1 = 1'b0;
  bit  m_live = 1'b0;
  bit  m_push;
  bit  m_multi;

  function automatic logic [PW-1:0] model_sel(input logic [N-1:0] e, input int prio);
    int low;
    low = 0;
    for (int j = N - 1; j >= 0; j--) if (e[j]) low = j;
    if ($countones(e) > 1 && prio == 0) return '0;
    return {2'(low), data[low]};
  endfunction

  function automatic logic [1:0] exp_state(input int occ);
    if (occ == 0) return BUF_EMPTY;
    if (occ == 1) return BUF_ONE;
    return BUF_FULL;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      m_cnt0 = 0;
      m_cnt1 = 0;
      m_flg0 = 1'b0;
      m_flg1 = 1'b0;
      m_live = 1'b0;
    end else begin
      m_push  = (en != '0) && m_live && (exp_q0.size() < 2);
      m_multi = ($countones(en) > 1);
      if (out_ready && exp_q0.size() > 0) begin
        void'(exp_q0.pop_front());
        void'(exp_q1.pop_front());
      end
      if (m_push) begin
        exp_q0.push_back(model_sel(en, 0));
        exp_q1.push_back(model_sel(en, 1));
      end
      if (clear) begin
        m_cnt0 = 0; m_cnt1 = 0; m_flg0 = 1'b0; m_flg1 = 1'b0;
      end else if (m_push && m_multi) begin
        m_flg0 = 1'b1;
        m_flg1 = 1'b1;
        if (m_cnt0 < 65535) m_cnt0++;
        if (m_cnt1 < 15) m_cnt1++;
      end
      m_live = 1'b1;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("in_ready0", 64'(if0.in_ready_o), 64'(m_live && exp_q0.size() < 2));
      check("in_ready1", 64'(if1.in_ready_o), 64'(m_live && exp_q1.size() < 2));
      check("out_valid0", 64'(if0.out_valid_o), 64'(exp_q0.size() > 0));
      check("out_valid1", 64'(if1.out_valid_o), 64'(exp_q1.size() > 0));
      check("state0", 64'(st0), 64'(exp_state(exp_q0.size())));
      check("conflict0", 64'(conf0), 64'(m_flg0));
      check("conflict1", 64'(conf1), 64'(m_flg1));
      check("cnt0", 64'(cnt0_o), 64'(m_cnt0));
      check("cnt1", 64'(cnt1_o), 64'(m_cnt1));
      if (exp_q0.size() > 0) check("payload0", 64'({if0.sel_idx_o, if0.Ez_n_o}), 64'(exp_q0[0]));
      if (exp_q1.size() > 0) check("payload1", 64'({if1.sel_idx_o, if1.Ez_n_o}), 64'(exp_q1[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [N-1:0] e, input logic r, input logic c);
    en        = e;
    out_ready = r;
    clear     = c;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_inputs('0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) data[i] = '0;
    #1 chk_on = 1'b1;
    repeat (3) step();
    check("rst_in_ready", 64'(if0.in_ready_o), 64'd0);
    check("rst_out_valid", 64'(if0.out_valid_o), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    check("in_ready_after_release", 64'(if0.in_ready_o), 64'd1);

    // single-hot, ready high
    data[1] = 32'hFFFF_FF9C;
    set_inputs(4'b0010, 1'b1, 1'b0);
    step();
    check("t1_valid", 64'(if0.out_valid_o), 64'd1);
    check("t1_ez", 64'({if0.Ez_n_o}), 64'h0000_0000_FFFF_FF9C);
    check("t1_idx", 64'(if0.sel_idx_o), 64'd1);
    check("t1_conflict", 64'(conf0), 64'd0);

    // conflict in both modes
    data[1] = 32'h0000_1234;
    data[2] = 32'h0000_5678;
    set_inputs(4'b0110, 1'b1, 1'b0);
    step();
    check("t2_strict_ez", 64'({if0.Ez_n_o}), 64'd0);
    check("t2_strict_idx", 64'(if0.sel_idx_o), 64'd0);
    check("t2_strict_conf", 64'(conf0), 64'd1);
    check("t2_strict_cnt", 64'(cnt0_o), 64'd1);
    check("t2_prio_ez", 64'({if1.Ez_n_o}), 64'h1234);
    check("t2_prio_idx", 64'(if1.sel_idx_o), 64'd1);
    check("t2_prio_cnt", 64'(cnt1_o), 64'd1);
    set_inputs('0, 1'b1, 1'b1);
    step();
    check("t2_clear_cnt", 64'(cnt0_o), 64'd0);
    check("t2_clear_conf", 64'(conf0), 64'd0);

    // back-pressure: 1 and 2 accepted, 3 refused
    data[0] = 32'd1;
    set_inputs(4'b0001, 1'b0, 1'b0);
    step();
    check("bp_ez_a", 64'({if0.Ez_n_o}), 64'd1);
    check("bp_ready_a", 64'(if0.in_ready_o), 64'd1);
    data[0] = 32'd2;
    step();
    check("bp_ready_b", 64'(if0.in_ready_o), 64'd0);
    check("bp_ez_b", 64'({if0.Ez_n_o}), 64'd1);
    data[0] = 32'd3;
    step();
    check("bp_ez_c", 64'({if0.Ez_n_o}), 64'd1);
    set_inputs('0, 1'b1, 1'b0);
    step();
    check("bp_ez_d", 64'({if0.Ez_n_o}), 64'd2);
    check("bp_valid_d", 64'(if0.out_valid_o), 64'd1);
    step();
    check("bp_valid_e", 64'(if0.out_valid_o), 64'd0);

    // counter saturation, then clear beats a simultaneous conflict
    set_inputs(4'b0011, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      data[0] = $urandom;
      data[1] = $urandom;
      step();
    end
    check("sat_cnt4", 64'(cnt1_o), 64'd15);
    check("sat_cnt16", 64'(cnt0_o), 64'd20);
    set_inputs(4'b0011, 1'b1, 1'b1);
    step();
    check("clr_win_cnt", 64'(cnt1_o), 64'd0);
    check("clr_win_conf", 64'(conf1), 64'd0);
    set_inputs('0, 1'b1, 1'b0);
    step();

    // reset mid-stream with a full buffer
    set_inputs(4'b0101, 1'b0, 1'b0);
    step();
    set_inputs(4'b0100, 1'b0, 1'b0);
    step();
    check("mid_full", 64'(if0.in_ready_o), 64'd0);
    set_inputs('0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(if0.out_valid_o), 64'd0);
    check("mid_rst_cnt", 64'(cnt0_o), 64'd0);
    repeat (2) step();
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();
    check("mid_no_stale", 64'(if0.out_valid_o), 64'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) en = '0;
      else if (r < 7) en = 4'(1 << $urandom_range(0, 3));
      else en = 4'($urandom_range(1, 15));
      for (int j = 0; j < N; j++) data[j] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 31) == 0);
      step();
    end

    set_inputs('0, 1'b1, 1'b0);
    repeat (3) step();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/fdtd_ez_select_pipe.md
Name: fdtd_ez_select_pipe

Overview:
- Parametrised, registered successor to the two-way Ez source selector in the FDTD update path.
- Selects one of NUM_SRC field-value sources: Ez_total, load_source, boundary and PML injection taps.
- Selection uses per-source enables. Illegal enable patterns are flagged and counted.
- Result goes through a valid/ready output with a 2-entry skid buffer, so a stalled FDTD write-back stage never drops a sample.

Parameters:
- FDTD_DATA_WIDTH, 32: width of each signed Ez sample.
- NUM_SRC, 4: number of selectable sources (2..16).
- PRIO_MODE, 0: conflict resolution.
  - 0 = strict one-hot; a multi-hot pattern outputs zero and flags.
  - 1 = lowest index wins and flags.
- CNT_WIDTH, 16: width of the saturating conflict counter.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear of the counter and sticky flag
- src_en_i  in  NUM_SRC  per-source enables; bit k selects source k
- src_data_i  in  NUM_SRC x FDTD_DATA_WIDTH  signed source samples, packed; source k occupies bits [k*W +: W]
- in_ready_o  out  1  block can accept a selection this cycle
- out_valid_o  out  1  Ez_n_o holds a valid sample
- out_ready_i  in  1  downstream accepts the sample
- Ez_n_o  out  FDTD_DATA_WIDTH  selected signed Ez sample
- sel_idx_o  out  $clog2(NUM_SRC)  index of the source behind Ez_n_o; 0 when the sample was zeroed
- conflict_o  out  1  sticky; set on any multi-hot enable pattern that is accepted
- conflict_cnt_o  out  CNT_WIDTH  saturating count of accepted multi-hot patterns

Behaviour:
- Reset (RST_N low, asynchronous): all outputs, skid entries, counter and flag go to 0. in_ready_o is 0 during reset and becomes 1 on the first clock edge after release.
- Input transfer: occurs when |src_en_i is 1 and in_ready_o is 1. An all-zero src_en_i is never a transfer; it produces no sample and no flag.
- Selection (combinational, captured on transfer):
  - Exactly one bit set: data and index of that source.
  - More than one bit set, PRIO_MODE=0: data 0, index 0.
  - More than one bit set, PRIO_MODE=1: lowest set index.
  - Multi-hot in either mode: conflict_o is set and conflict_cnt_o increments, saturating at all-ones.
- Data is passed bit-exact; no sign extension or arithmetic.
- Buffer: 2 entries, main and skid, with a 1-cycle latency from transfer to out_valid_o.
- Buffer states: EMPTY, ONE (main valid), FULL (main and skid valid).
  - EMPTY + transfer -> ONE.
  - ONE + transfer and !out_ready_i -> FULL; the new sample goes to skid.
  - ONE + out_ready_i and no transfer -> EMPTY.
  - ONE + transfer and out_ready_i -> ONE; main takes the new sample.
  - FULL + out_ready_i -> ONE; skid moves to main.
  - FULL: no transfer is possible.
- in_ready_o = state != FULL. It is registered, so there is no combinational path from out_ready_i.
- Ordering: strict FIFO. Ez_n_o and sel_idx_o stay stable while out_valid_o=1 and out_ready_i=0.
- clear_i: zeroes the counter and flag the next cycle. If clear_i and a conflict occur in the same cycle, clear wins: the result is counter 0 and flag 0.
- Reset mid-operation: buffered samples are discarded and there is no partial output.

Decomposition:
- Package fdtd_pkg:
  - localparams for PRIO_MODE values (FDTD_SEL_STRICT=0, FDTD_SEL_PRIO=1).
  - typedef fdtd_data_t = logic signed [FDTD_DATA_WIDTH-1:0].
  - buffer-state enum {EMPTY, ONE, FULL}.
- Sub-module fdtd_skid_buf:
  - Generic 2-entry valid/ready buffer, parametrised on payload width (data plus index).
  - Reusable for the Hy/Hx paths.
- Selection, conflict detection and the counter stay in the top module.

Test Plan:
- Single-hot, ready high: src_en_i=4'b0010, source1=32'hFFFF_FF9C (-100) -> next cycle out_valid_o=1, Ez_n_o=-100, sel_idx_o=1, conflict_o=0.
- Conflict, PRIO_MODE=0: src_en_i=4'b0110 -> Ez_n_o=0, sel_idx_o=0, conflict_o=1, conflict_cnt_o=1.
- Same stimulus with PRIO_MODE=1 -> Ez_n_o=source1, sel_idx_o=1, counter=1.
- Back-pressure: out_ready_i=0, then three consecutive transfers with values 1,2,3.
  - Only 1 and 2 are accepted; in_ready_o=0 after the second.
  - Raising out_ready_i yields 1 then 2 in order, each held stable while stalled.
- Counter saturation with CNT_WIDTH=4: 20 multi-hot transfers -> conflict_cnt_o=15. clear_i together with one more conflict -> counter 0, flag 0.
- Reset mid-stream: FULL buffer, assert RST_N low between clock edges -> out_valid_o=0 immediately, counter 0. After release, no stale sample appears.
